// File: rtl/seq_detector_param.sv
// ---------------------------------------------------------------------------
// seq_detector_param
// Parametrised Moore serial-pattern detector. One serial bit is consumed on
// every clock edge with en_i=1. Match progress is tracked as a state index
// 0..PAT_W. The transitions come from a KMP automaton table that is built
// once at elaboration, so no pattern storage exists at runtime.
//
// Every output comes straight from a flop. y_o and st_literal_o are
// registered from the next-state value, so they change on the same edge as
// the state. No combinational path runs from x_i/en_i to any output.
// ---------------------------------------------------------------------------
module seq_detector_param #(
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b1100,
    parameter bit               OVERLAP = 1'b1,
    parameter int               CNT_W   = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic             x_i,
    input  logic             clr_i,
    output logic             y_o,
    output logic [3:0]       prog_o,
    output logic [CNT_W-1:0] match_cnt_o,
    output logic [7:0]       st_literal_o
);

    // -----------------------------------------------------------------------
    // Elaboration-time transition table.
    // Entry (k, b) is 4 bits wide and sits at bit offset (k*2 + b)*4.
    // Its value is the longest prefix of the pattern (length <= PAT_W) that
    // is a suffix of (first k pattern bits followed by b).
    // - On a match this naturally yields k+1.
    // - From the full state it yields the overlapping KMP fallback.
    // Rows for indices above PAT_W stay zero. A corrupted state index
    // therefore falls back to S0 on the next enabled edge.
    // -----------------------------------------------------------------------
    function automatic logic [127:0] build_next_table();
        logic [127:0] tbl;
        logic [16:0]  p17;
        logic [16:0]  s_val;
        logic [16:0]  mask;
        logic [16:0]  pre;
        logic [16:0]  suf;
        int           len;
        int           best;
        tbl = 128'd0;
        p17 = 17'(PATTERN);
        for (int k = 0; k <= PAT_W; k++) begin
            for (int b = 0; b < 2; b++) begin
                // received string as a number, newest bit in the LSB
                s_val = ((p17 >> (PAT_W - k)) << 1) | 17'(b);
                len   = k + 1;
                best  = 0;
                for (int j = 1; j <= PAT_W; j++) begin
                    if (j <= len) begin
                        mask = (17'd1 << j) - 17'd1;
                        pre  = p17 >> (PAT_W - j);
                        suf  = s_val & mask;
                        if (pre == suf) begin
                            best = j;
                        end
                    end
                end
                tbl = tbl | (128'(best) << ((k * 2 + b) * 4));
            end
        end
        // Non-overlapping search: the full state behaves like S0.
        if (!OVERLAP) begin
            tbl = (tbl & ~(128'hFF << (PAT_W * 8)))
                | ((tbl & 128'hFF) << (PAT_W * 8));
        end
        return tbl;
    endfunction

    // Active-low common-anode hex glyph, segments {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex_glyph(input logic [3:0] v);
        logic [6:0] g;
        case (v)
            4'h0:    g = 7'h40;
            4'h1:    g = 7'h79;
            4'h2:    g = 7'h24;
            4'h3:    g = 7'h30;
            4'h4:    g = 7'h19;
            4'h5:    g = 7'h12;
            4'h6:    g = 7'h02;
            4'h7:    g = 7'h78;
            4'h8:    g = 7'h00;
            4'h9:    g = 7'h10;
            4'hA:    g = 7'h08;
            4'hB:    g = 7'h03;
            4'hC:    g = 7'h46;
            4'hD:    g = 7'h21;
            4'hE:    g = 7'h06;
            4'hF:    g = 7'h0E;
            default: g = 7'h7F;
        endcase
        return g;
    endfunction

    localparam logic [3:0]       S0        = 4'd0;
    localparam logic [3:0]       S_FULL    = 4'(PAT_W);
    localparam logic [127:0]     NXT_TBL   = build_next_table();
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [7:0]       LIT_RESET = 8'hC0;

    logic [3:0]       state_q;
    logic [3:0]       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             y_q;
    logic             y_d;
    logic [7:0]       lit_q;
    logic [7:0]       lit_d;
    logic [6:0]       tbl_idx_s;

    // Next state and match counter: clr has priority over en, en=0 holds.
    always_comb begin
        tbl_idx_s = {state_q, x_i, 2'b00};
        state_d   = state_q;
        cnt_d     = cnt_q;
        if (clr_i) begin
            state_d = S0;
            cnt_d   = {CNT_W{1'b0}};
        end else if (en_i) begin
            state_d = NXT_TBL[tbl_idx_s +: 4];
            if ((state_d == S_FULL) && (cnt_q != CNT_MAX)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end else begin
                cnt_d = cnt_q;
            end
        end else begin
            state_d = state_q;
            cnt_d   = cnt_q;
        end
    end

    // Output decode of the next state, captured so outputs leave flops directly.
    always_comb begin
        y_d   = (state_d == S_FULL);
        lit_d = {~y_d, hex_glyph(state_d)};
    end

    // State and counter registers with asynchronous active-low reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S0;
            cnt_q   <= {CNT_W{1'b0}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Registered match flag and display literal, updated in step with the state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            y_q   <= 1'b0;
            lit_q <= LIT_RESET;
        end else begin
            y_q   <= y_d;
            lit_q <= lit_d;
        end
    end

    assign y_o          = y_q;
    assign prog_o       = state_q;
    assign match_cnt_o  = cnt_q;
    assign st_literal_o = lit_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// ---------------------------------------------------------------------------
// tb_seq_detector_param
// Four detector configurations share one clock and one input stream:
//   0: 1100, overlap, 8-bit counter
//   1: 1010, overlap
//   2: 1010, no overlap
//   3: pattern "1", overlap, 2-bit counter
// The reference model keeps the history of received bits per configuration.
// Progress is the longest pattern prefix that ends the history. A
// non-overlapping configuration drops its history after each match.
// ---------------------------------------------------------------------------
module tb_seq_detector_param;

    logic clk;
    logic rst_n;
    logic en;
    logic x;
    logic clr;

    logic       y_s    [4];
    logic [3:0] prog_s [4];
    logic [7:0] lit_s  [4];
    logic [7:0] cnt0_s;
    logic [7:0] cnt1_s;
    logic [7:0] cnt2_s;
    logic [1:0] cnt3_s;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [15:0] pat_c [4] = '{16'h000C, 16'h000A, 16'h000A, 16'h0001};
    int          w_c   [4] = '{4, 4, 4, 1};
    bit          ovl_c [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    int          max_c [4] = '{255, 255, 255, 3};
    logic [7:0]  glyph_c [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                  8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    bit hist   [4][$];
    int prog_e [4];
    int cnt_e  [4];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    seq_detector_param #(.PAT_W(4), .PATTERN(4'b1100), .OVERLAP(1'b1), .CNT_W(8)) u_d0 (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en), .x_i(x), .clr_i(clr),
        .y_o(y_s[0]), .prog_o(prog_s[0]), .match_cnt_o(cnt0_s), .st_literal_o(lit_s[0]));
    seq_detector_param #(.PAT_W(4), .PATTERN(4'b1010), .OVERLAP(1'b1), .CNT_W(8)) u_d1 (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en), .x_i(x), .clr_i(clr),
        .y_o(y_s[1]), .prog_o(prog_s[1]), .match_cnt_o(cnt1_s), .st_literal_o(lit_s[1]));
    seq_detector_param #(.PAT_W(4), .PATTERN(4'b1010), .OVERLAP(1'b0), .CNT_W(8)) u_d2 (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en), .x_i(x), .clr_i(clr),
        .y_o(y_s[2]), .prog_o(prog_s[2]), .match_cnt_o(cnt2_s), .st_literal_o(lit_s[2]));
    seq_detector_param #(.PAT_W(1), .PATTERN(1'b1), .OVERLAP(1'b1), .CNT_W(2)) u_d3 (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en), .x_i(x), .clr_i(clr),
        .y_o(y_s[3]), .prog_o(prog_s[3]), .match_cnt_o(cnt3_s), .st_literal_o(lit_s[3]));

    function automatic logic [7:0] cnt_obs(logic [1:0] c);
        logic [7:0] v;
        case (c)
            2'd0:    v = cnt0_s;
            2'd1:    v = cnt1_s;
            2'd2:    v = cnt2_s;
            default: v = {6'b000000, cnt3_s};
        endcase
        return v;
    endfunction

    // Longest pattern prefix that is a suffix of the received history.
    function automatic int longest(logic [1:0] c);
        int          n;
        int          best;
        bit          ok;
        logic [15:0] sh;
        n    = hist[c].size();
        best = 0;
        for (int j = 1; j <= w_c[c]; j++) begin
            if (j <= n) begin
                ok = 1'b1;
                for (int i = 0; i < j; i++) begin
                    sh = pat_c[c] >> (w_c[c] - 1 - i);
                    if (hist[c][n - j + i] != sh[0]) ok = 1'b0;
                end
                if (ok) best = j;
            end
        end
        return best;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 4; c++) begin
            hist[c].delete();
            prog_e[c] = 0;
            cnt_e[c]  = 0;
        end
    endtask

    task automatic model_edge(logic e, logic xv, logic cl);
        int p;
        for (int c = 0; c < 4; c++) begin
            if (cl) begin
                hist[c].delete();
                prog_e[c] = 0;
                cnt_e[c]  = 0;
            end else if (e) begin
                hist[c].push_back(xv);
                if (hist[c].size() > 16) void'(hist[c].pop_front());
                p = longest(2'(c));
                if (p == w_c[c]) begin
                    if (cnt_e[c] < max_c[c]) cnt_e[c] = cnt_e[c] + 1;
                    if (!ovl_c[c]) hist[c].delete();
                end
                prog_e[c] = p;
            end
        end
    endtask

    task automatic chk(string tag, logic [1:0] c, logic [7:0] obs, logic [7:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s dut%0d observed=%h expected=%h", tag, c, obs, exp);
        end
    endtask

    task automatic check_one(logic [1:0] c);
        bit         y_exp;
        logic [3:0] pi;
        logic [7:0] g;
        y_exp = (prog_e[c] == w_c[c]);
        pi    = 4'(prog_e[c]);
        g     = glyph_c[pi];
        chk("prog", c, {4'b0000, prog_s[c]}, 8'(prog_e[c]));
        chk("y",    c, {7'b0000000, y_s[c]}, {7'b0000000, y_exp});
        chk("cnt",  c, cnt_obs(c), 8'(cnt_e[c]));
        chk("lit",  c, lit_s[c], {~y_exp, g[6:0]});
    endtask

    task automatic check_all();
        for (int c = 0; c < 4; c++) check_one(2'(c));
    endtask

    // Drive inputs away from the edge, clock once, update model, sample at +1.
    task automatic step(logic e, logic xv, logic cl);
        en  = e;
        x   = xv;
        clr = cl;
        @(posedge clk);
        model_edge(e, xv, cl);
        #1;
        check_all();
    endtask

    // Reset pulse between edges; outputs must clear before the next edge.
    task automatic async_reset();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        chk("rst_lit", 2'd0, lit_s[0], 8'hC0);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        bit   t1_x [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        int   t1_p [4] = '{1, 2, 3, 4};
        bit   t2_x [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        int   t2_p [6] = '{1, 2, 2, 3, 4, 1};
        bit   t3_x [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        int   t3_p1 [6] = '{1, 2, 3, 4, 3, 4};
        int   t3_p2 [6] = '{1, 2, 3, 4, 1, 2};
        int   t5_c [5] = '{1, 2, 3, 3, 3};
        logic re;
        logic rx;
        logic rc;

        rst_n = 1'b0;
        en    = 1'b0;
        x     = 1'b0;
        clr   = 1'b0;
        model_reset();
        #12;
        check_all();
        chk("reset_lit", 2'd0, lit_s[0], 8'hC0);
        #1;
        rst_n = 1'b1;

        // Basic 1100 detection
        for (int i = 0; i < 4; i++) begin
            step(1'b1, t1_x[i], 1'b0);
            chk("t1_prog", 2'd0, {4'b0000, prog_s[0]}, 8'(t1_p[i]));
        end
        chk("t1_y", 2'd0, {7'b0000000, y_s[0]}, 8'h01);
        chk("t1_cnt", 2'd0, cnt0_s, 8'h01);
        chk("t1_lit", 2'd0, lit_s[0], 8'h19);

        // KMP fallback on 11100 then a restart bit
        step(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            step(1'b1, t2_x[i], 1'b0);
            chk("t2_prog", 2'd0, {4'b0000, prog_s[0]}, 8'(t2_p[i]));
        end
        chk("t2_cnt", 2'd0, cnt0_s, 8'h01);
        chk("t2_lit", 2'd0, lit_s[0], 8'hF9);

        // Overlapping vs non-overlapping 1010
        step(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            step(1'b1, t3_x[i], 1'b0);
            chk("t3_prog_ovl", 2'd1, {4'b0000, prog_s[1]}, 8'(t3_p1[i]));
            chk("t3_prog_novl", 2'd2, {4'b0000, prog_s[2]}, 8'(t3_p2[i]));
        end
        chk("t3_cnt_ovl", 2'd1, cnt1_s, 8'h02);
        chk("t3_cnt_novl", 2'd2, cnt2_s, 8'h01);

        // Enable gating
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b0);
            chk("t4_hold", 2'd0, {4'b0000, prog_s[0]}, 8'h02);
        end
        step(1'b1, 1'b0, 1'b0);
        chk("t4_prog3", 2'd0, {4'b0000, prog_s[0]}, 8'h03);
        step(1'b1, 1'b0, 1'b0);
        chk("t4_prog4", 2'd0, {4'b0000, prog_s[0]}, 8'h04);
        chk("t4_cnt", 2'd0, cnt0_s, 8'h01);

        // Saturation of the 2-bit counter, then clr beating en
        step(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b1, 1'b0);
            chk("t5_cnt", 2'd3, {6'b000000, cnt3_s}, 8'(t5_c[i]));
            chk("t5_y", 2'd3, {7'b0000000, y_s[3]}, 8'h01);
        end
        step(1'b1, 1'b1, 1'b1);
        chk("t5_clr_prog", 2'd3, {4'b0000, prog_s[3]}, 8'h00);
        chk("t5_clr_cnt", 2'd3, {6'b000000, cnt3_s}, 8'h00);
        chk("t5_clr_y", 2'd3, {7'b0000000, y_s[3]}, 8'h00);

        // Asynchronous reset mid-sequence
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        chk("t6_pre", 2'd0, {4'b0000, prog_s[0]}, 8'h03);
        async_reset();
        chk("t6_prog0", 2'd0, {4'b0000, prog_s[0]}, 8'h00);
        step(1'b1, 1'b1, 1'b0);
        chk("t6_after", 2'd0, {4'b0000, prog_s[0]}, 8'h01);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            re = ($urandom_range(0, 3) != 0);
            rx = 1'($urandom_range(0, 1));
            rc = ($urandom_range(0, 47) == 0);
            step(re, rx, rc);
            if ($urandom_range(0, 99) == 0) async_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
- Parametrised Moore serial-pattern detector; successor to the fixed 4-bit one-hot "1100" detector.
- Samples one serial bit per enabled clock and tracks match progress against a compile-time pattern of any length.
- Asserts a Moore match flag and counts matches.
- Drives a common-anode 7-segment literal showing current progress (0..PAT_W), so the board display works for any pattern.

Parameters:
- PAT_W, 4, pattern length in bits; legal range 1..15.
- PATTERN, 4'b1100, pattern bits; PATTERN[PAT_W-1] is the first bit received.
- OVERLAP, 1, 1 = overlapping matches allowed; 0 = restart search after each match.
- CNT_W, 8, width of the saturating match counter.

Ports:
- Clock  input  1  rising-edge clock.
- Reset  input  1  asynchronous, active-low reset.
- en  input  1  sample strobe; x is consumed only on a clock edge with en=1.
- x  input  1  serial data bit.
- clr  input  1  synchronous clear of progress and counter.
- y  output  1  Moore match flag; high while progress == PAT_W.
- prog  output  4  current progress state index, 0..PAT_W.
- match_cnt  output  CNT_W  number of matches; saturates.
- st_literal  output  8  7-segment pattern {dp,g,f,e,d,c,b,a}, active-low.

Behaviour:
- States: S0..S_PAT_W. prog = state index. Encoding is free; all outputs decode from registered state only (Moore).
- Reset (Reset=0, asynchronous): state S0, y=0, prog=0, match_cnt=0, st_literal=8'hC0. Applies immediately, including mid-sequence.
- Edge with clr=1: state S0, match_cnt=0. clr has priority over en.
- Edge with en=0, clr=0: state and counter hold.
- Edge with en=1, clr=0, from state Sk with k<PAT_W:
  - next = Sk+1 if x equals expected bit PATTERN[PAT_W-1-k].
  - Otherwise next = Sj, where j is the longest proper prefix of the pattern that is a suffix of (the received k-bit prefix followed by x). This is the KMP fallback; it may be S0.
  - The transition table is computed at elaboration. There is no runtime pattern storage.
- From S_PAT_W with en=1:
  - OVERLAP=1: treat as k=PAT_W with no expected bit and apply the KMP fallback on (full pattern followed by x).
  - OVERLAP=0: next state is the S0 transition for x.
- y=1 exactly while the state is S_PAT_W. It asserts on the edge that samples the completing bit and has zero extra latency beyond that register.
- match_cnt increments by 1 on every edge whose next state is S_PAT_W, including S_PAT_W to S_PAT_W transitions. It holds at 2^CNT_W-1 once reached.
- st_literal[6:0] is the hex glyph of prog, active-low:
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8 (bit7 shown as 1).
  - 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E.
- st_literal[7] (decimal point) = ~y, so the DP is lit while matched.
- Outputs are glitch-free functions of registers. No combinational path from x or en to any output.

Test Plan:
- Default params (PATTERN=1100), en=1, x=1,1,0,0 -> prog 1,2,3,4. y=1 only after the 4th edge. match_cnt=1. st_literal=8'h19 (glyph 4, DP lit).
- Fallback (default params), x=1,1,1,0,0 -> prog 1,2,2,3,4. One match. Then x=1 -> prog 1, y=0, st_literal=8'hF9.
- PAT_W=4, PATTERN=1010, x=1,0,1,0,1,0:
  - OVERLAP=1 -> prog 1,2,3,4,3,4; y high after edges 4 and 6; match_cnt=2.
  - OVERLAP=0 -> prog 1,2,3,4,1,2; match_cnt=1.
- en gating (default params): x=1,1 with en=1, then 3 edges with en=0 and x=0, then en=1 with x=0,0 -> prog holds at 2 during en=0, then 3,4. match_cnt=1.
- Saturation and clr, CNT_W=2, PATTERN=1 (PAT_W=1), OVERLAP=1, x=1 for 5 edges -> match_cnt 1,2,3,3,3 and y stays 1. clr=1 with en=1 -> prog=0, match_cnt=0, y=0.
- Async reset: drive Reset low between edges while prog=3 -> prog=0, y=0, match_cnt=0, st_literal=8'hC0 immediately, before the next edge. After release, the first enabled x=1 -> prog=1.
